// File: rtl/dm_unlock_pkg.sv
// Shared types and widths for the DMI unlock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_unlock_pkg;

    localparam int unsigned WordWidth   = 32;
    localparam int unsigned DefNumWords = 16;
    localparam int unsigned MsgWidth    = WordWidth * DefNumWords;
    localparam int unsigned HashWidth   = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_VALID,
        ST_LOCKOUT
    } unlock_state_e;

    // The watchdog and lockout timers share one down-counter that only ever
    // holds (limit - 1), so it needs enough bits for the larger limit minus one.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dmi_unlock_ctrl_if.sv
// Handshake bundles between the unlock sequencer, the DTM and the HMAC engine.
// Latency: n/a (wires only).
// Backpressure: pass stream is valid/ready; HMAC side uses init/ready/valid.
//
// dmi_pass_if : pass_valid, pass_word (DTM -> ctrl), pass_ready (ctrl -> DTM)
//   master = DTM (word source), slave = unlock controller (word sink)
// dmi_hmac_if : hmac_init, hmac_msg (ctrl -> engine),
//               hmac_ready, hmac_valid, hmac_hash (engine -> ctrl)
//   master = unlock controller, slave = HMAC engine
interface dmi_pass_if;
    logic        pass_valid;
    logic [31:0] pass_word;
    logic        pass_ready;

    modport master (output pass_valid, output pass_word, input  pass_ready);
    modport slave  (input  pass_valid, input  pass_word, output pass_ready);
endinterface

interface dmi_hmac_if #(
    parameter int unsigned NumWords = dm_unlock_pkg::DefNumWords
);
    logic                                 hmac_init;
    logic [32*NumWords-1:0]               hmac_msg;
    logic                                 hmac_ready;
    logic                                 hmac_valid;
    logic [dm_unlock_pkg::HashWidth-1:0]  hmac_hash;

    modport master (
        output hmac_init, output hmac_msg,
        input  hmac_ready, input hmac_valid, input hmac_hash
    );
    modport slave (
        input  hmac_init, input hmac_msg,
        output hmac_ready, output hmac_valid, output hmac_hash
    );
endinterface

// File: rtl/dmi_unlock_ctrl.sv
// Collects a password, runs it through HMAC and unlocks debug on digest match.
// Latency: NumWords cycles to collect, then engine-bound (watchdog TimeoutCycles).
// Backpressure: pass_ready low outside IDLE/COLLECT; lockout after MaxAttempts fails.
//
// Ports: tck_i / trst_ni (async, active-low) clock and reset; clear_i sync abort;
//   relock_i drops unlock; pass (slave) password word stream; hmac (master)
//   engine handshake and message; exp_hash_i provisioned digest; unlock_o,
//   lockout_o, busy_o status; fail_cnt_o consecutive failed attempts.
module dmi_unlock_ctrl
    import dm_unlock_pkg::*;
#(
    parameter int unsigned NumWords      = DefNumWords,
    parameter int unsigned MaxAttempts   = 3,
    parameter int unsigned LockoutCycles = 1024,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                              tck_i,
    input  logic                              trst_ni,
    input  logic                              clear_i,
    input  logic                              relock_i,
    dmi_pass_if.slave                         pass,
    dmi_hmac_if.master                        hmac,
    input  logic [HashWidth-1:0]              exp_hash_i,
    output logic                              unlock_o,
    output logic                              lockout_o,
    output logic                              busy_o,
    output logic [$clog2(MaxAttempts+1)-1:0]  fail_cnt_o
);

    localparam int unsigned FailW = $clog2(MaxAttempts + 1);
    localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntW  = cnt_width(TimeoutCycles, LockoutCycles);

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumWords - 1);
    localparam logic [CntW-1:0]  WdLoad   = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0]  LockLoad = CntW'(LockoutCycles - 1);
    localparam logic [FailW-1:0] FailMax  = FailW'(MaxAttempts);

    unlock_state_e state_q, state_d;

    logic [NumWords-1:0][31:0] msg_q;
    logic [IdxW-1:0]           idx_q;
    logic [CntW-1:0]           cnt_q;
    logic [FailW-1:0]          fail_q;
    logic [FailW-1:0]          fail_inc;
    logic                      unlock_q;

    logic store_en;
    logic first_word;
    logic buf_clr;
    logic load_wd;
    logic load_lock;
    logic match_evt;
    logic fail_evt;
    logic lock_done;
    logic cnt_zero;
    logic counting;

    assign fail_inc = fail_q + 1'b1;
    assign cnt_zero = (cnt_q == '0);
    assign counting = (state_q == ST_START) || (state_q == ST_WAIT_BUSY) ||
                      (state_q == ST_WAIT_VALID) || (state_q == ST_LOCKOUT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. clear_i is checked first in every
    // active state so a coincident word or engine result is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        pass.pass_ready = 1'b0;
        hmac.hmac_init  = 1'b0;
        store_en        = 1'b0;
        first_word      = 1'b0;
        buf_clr         = 1'b0;
        load_wd         = 1'b0;
        load_lock       = 1'b0;
        match_evt       = 1'b0;
        fail_evt        = 1'b0;
        lock_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pass.pass_ready = 1'b1;
                if (clear_i) begin
                    buf_clr = 1'b1;
                end else if (pass.pass_valid) begin
                    store_en   = 1'b1;
                    first_word = 1'b1;
                    if (NumWords == 1) begin
                        load_wd = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                pass.pass_ready = 1'b1;
                if (clear_i) begin
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (pass.pass_valid) begin
                    store_en = 1'b1;
                    if (idx_q == LastIdx) begin
                        load_wd = 1'b1;
                        state_d = ST_START;
                    end
                end
            end

            // Timeout wins over a late-arriving ready so no init is issued
            // on the cycle the attempt is being abandoned.
            ST_START: begin
                if (clear_i) begin
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    fail_evt = 1'b1;
                end else if (hmac.hmac_ready) begin
                    hmac.hmac_init = 1'b1;
                    state_d        = ST_WAIT_BUSY;
                end
            end

            // Valid seen here belongs to an earlier hash and is ignored.
            ST_WAIT_BUSY: begin
                if (clear_i) begin
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    fail_evt = 1'b1;
                end else if (!hmac.hmac_ready) begin
                    state_d = ST_WAIT_VALID;
                end
            end

            // A digest arriving on the last watchdog cycle is still honoured.
            ST_WAIT_VALID: begin
                if (clear_i) begin
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (hmac.hmac_valid) begin
                    if (hmac.hmac_hash == exp_hash_i) begin
                        match_evt = 1'b1;
                        buf_clr   = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end else if (cnt_zero) begin
                    fail_evt = 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (cnt_zero) begin
                    lock_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mismatch and watchdog expiry share one exit path.
        if (fail_evt) begin
            buf_clr = 1'b1;
            if (fail_inc == FailMax) begin
                load_lock = 1'b1;
                state_d   = ST_LOCKOUT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Message buffer and write index. The index is back at zero whenever
    // the FSM is in IDLE, so the first word always lands in slot 0.
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            msg_q <= '0;
            idx_q <= '0;
        end else if (buf_clr) begin
            msg_q <= '0;
            idx_q <= '0;
        end else if (store_en) begin
            msg_q[idx_q] <= pass.pass_word;
            idx_q        <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shared watchdog / lockout down-counter. Loaded with limit-1 on entry
    // so the state is occupied for exactly the limit in cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            cnt_q <= '0;
        end else if (load_wd) begin
            cnt_q <= WdLoad;
        end else if (load_lock) begin
            cnt_q <= LockLoad;
        end else if (counting && !cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Failure counter and unlock flag. relock_i outranks a same-cycle match.
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            fail_q <= '0;
        end else if (lock_done || match_evt) begin
            fail_q <= '0;
        end else if (fail_evt) begin
            fail_q <= fail_inc;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            unlock_q <= 1'b0;
        end else if (relock_i) begin
            unlock_q <= 1'b0;
        end else if (match_evt) begin
            unlock_q <= 1'b1;
        end else if (first_word) begin
            unlock_q <= 1'b0;
        end
    end

    assign hmac.hmac_msg = msg_q;
    assign unlock_o      = unlock_q;
    assign lockout_o     = (state_q == ST_LOCKOUT);
    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_LOCKOUT);
    assign fail_cnt_o    = fail_q;

endmodule

// File: doc/dmi_unlock_ctrl.md
# dmi_unlock_ctrl

JTAG-side sequencer that gates debug-module write access behind an HMAC password check. It collects a 512-bit password from the DTM as sixteen 32-bit words, drives the shared HMAC engine through its init/ready/valid handshake, and compares the resulting digest with the provisioned expected hash. It owns the unlock flag, the failed-attempt counter and the brute-force lockout, and sits between the DMI state machine and the HMAC instance in the TCK domain.

## Interface
- NumWords, 16: 32-bit words per password (message width = 32*NumWords).
- MaxAttempts, 3: consecutive failures that trigger lockout.
- LockoutCycles, 1024: TCK cycles spent in lockout.
- TimeoutCycles, 4096: HMAC watchdog; expiry counts as a failed attempt.
- tck_i  in  1  clock; all ports are in the tck_i domain; CDC toward hmac is the integrator's job.
- trst_ni  in  1  reset trst_ni, asynchronous, active-low.
- clear_i  in  1  sync abort (dmi_reset / test_logic_reset).
- relock_i  in  1  sync request to drop unlock.
- pass_valid_i  in  1  password word valid.
- pass_word_i  in  32  password word.
- pass_ready_o  out  1  word accepted when valid && ready.
- hmac_init_o  out  1  single-cycle start pulse.
- hmac_msg_o  out  32*NumWords  message; word k at bits [32k+31:32k].
- hmac_ready_i  in  1  engine idle.
- hmac_valid_i  in  1  digest valid.
- hmac_hash_i  in  256  digest.
- exp_hash_i  in  256  expected digest (static).
- unlock_o  out  1  registered unlock flag.
- lockout_o  out  1  high while in LOCKOUT.
- busy_o  out  1  high in any state other than IDLE or LOCKOUT.
- fail_cnt_o  out  $clog2(MaxAttempts+1)  consecutive failures.

## Operation
- States: IDLE, COLLECT, START, WAIT_BUSY, WAIT_VALID, LOCKOUT.
- IDLE: pass_ready_o=1. On an accepted word: store it at index 0, set word count to 1, clear unlock_o, go to COLLECT.
- COLLECT: pass_ready_o=1. Each accepted word is stored at the current index and the index increments. Acceptance of word NumWords-1 goes to START.
- START: pass_ready_o=0. hmac_init_o=1 for exactly the first cycle with hmac_ready_i=1, then go to WAIT_BUSY.
- WAIT_BUSY: wait for hmac_ready_i=0, then go to WAIT_VALID. Any hmac_valid_i seen here is ignored as stale.
- WAIT_VALID: on hmac_valid_i, compare hmac_hash_i with exp_hash_i.
  - Match: unlock_o<=1, fail_cnt<=0, go to IDLE.
  - Mismatch: fail_cnt++. If the new count equals MaxAttempts, go to LOCKOUT; otherwise go to IDLE.
- Watchdog: counts cycles spent in START, WAIT_BUSY and WAIT_VALID. Reaching TimeoutCycles is handled exactly as a mismatch.
- The message buffer is zeroed when leaving WAIT_VALID, on timeout, and on clear_i.
- LOCKOUT: pass_ready_o=0, lockout_o=1. After exactly LockoutCycles cycles: fail_cnt<=0, go to IDLE.
- clear_i:
  - From COLLECT or START, returns to IDLE with the buffer zeroed and no HMAC start.
  - In WAIT_BUSY or WAIT_VALID, the pending result is discarded, no attempt is counted, and the state returns to IDLE.
  - Ignored in LOCKOUT.
  - Never changes unlock_o or fail_cnt.
- relock_i: clears unlock_o in any state, with priority over a same-cycle match.
- unlock_o is sticky until relock_i, a new first word, or trst_ni.

## Timing
- Reset values:
  - State IDLE, counters 0, buffer 0.
  - unlock_o=0, lockout_o=0, busy_o=0, hmac_init_o=0, fail_cnt_o=0.
  - pass_ready_o=1.
- Minimum collection is NumWords consecutive cycles.
- hmac_init_o asserts no earlier than the cycle after the last word is accepted.
- unlock_o and fail_cnt_o update on the clock edge that samples hmac_valid_i in WAIT_VALID.
- lockout_o is asserted for exactly LockoutCycles cycles.
- A timeout fires on the TimeoutCycles-th cycle after entering START.
- Simultaneous pass_valid_i and clear_i: clear_i wins and the word is dropped.
- An asynchronous trst_ni mid-operation returns to the reset state immediately, including the buffer.

## Structure
- Shared package dm_unlock_pkg holds:
  - the state enum unlock_state_e;
  - the localparams for message width and hash width (256).
- Watchdog and lockout share one down-counter. No sub-module is needed: this is a single FSM plus counters and the buffer.

## Test plan
- 16 words 0x00000000..0x0000000F, hmac_hash_i==exp_hash_i -> one hmac_init_o pulse, hmac_msg_o[31:0]=0, [511:480]=0xF, unlock_o=1, fail_cnt_o=0.
- Three mismatching attempts -> fail_cnt_o goes 1, 2, 3; lockout_o=1 for exactly 1024 cycles; pass_ready_o=0 throughout; then fail_cnt_o=0.
- hmac_valid_i held high from a previous hash, then ready drops and valid pulses with the correct digest -> the stale valid is ignored and unlock occurs only on the new valid.
- Engine never responds -> timeout at 4096 cycles, fail_cnt_o=1, buffer zeroed.
- clear_i after 8 words -> IDLE, no init pulse; the next 16 words form a fresh message.
- unlock_o=1, then relock_i -> 0 next cycle; relock_i coincident with a matching hmac_valid_i -> unlock_o stays 0.
